// File: rtl/ofdm_pkg.sv
// Shared OFDM/FFT constants and the twiddle generator state type.
// Also holds the 16-bit two's complement negation helper.
package ofdm_pkg;

    localparam int FFT_LOG2N = 12;
    localparam int QUARTER   = 1024;
    localparam int TW_W      = 16;
    localparam int ROM_AW    = 11;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        OUT
    } tw_state_t;

    function automatic logic [TW_W-1:0] neg_tw(input logic [TW_W-1:0] x);
        return TW_W'(~x + 1'b1);
    endfunction

endpackage

// File: rtl/twiddle_fold.sv
// Quadrant folding of two quarter-wave sine samples into cos / -+sin.
// Purely combinational; operands never exceed 0x7FFF so negation cannot overflow.
module twiddle_fold
    import ofdm_pkg::*;
(
    input  logic [1:0]      q,
    input  logic            inv,
    input  logic [TW_W-1:0] ta,
    input  logic [TW_W-1:0] tb,
    output logic [TW_W-1:0] re,
    output logic [TW_W-1:0] im
);

    logic [TW_W-1:0] s;
    logic [TW_W-1:0] c;

    always_comb begin
        s = '0;
        c = '0;
        unique case (q)
            2'd0: begin s = ta;         c = tb;         end
            2'd1: begin s = tb;         c = neg_tw(ta); end
            2'd2: begin s = neg_tw(ta); c = neg_tw(tb); end
            2'd3: begin s = neg_tw(tb); c = ta;         end
        endcase
        re = c;
        im = inv ? s : neg_tw(s);
    end

endmodule

// File: rtl/twiddle_gen.sv
// FFT/IFFT twiddle generator: two reads of a shared quarter-wave sine ROM,
// then quadrant folding and sign restoration into registered Q1.15 outputs.
module twiddle_gen
    import ofdm_pkg::*;
#(
    parameter int LOG2N  = FFT_LOG2N,
    parameter int ROM_AW = 11,
    parameter int DW     = TW_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LOG2N-1:0]  in_k,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_re,
    output logic [DW-1:0]     out_im,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_ad,
    input  logic [DW-1:0]     rom_dout
);

    tw_state_t        state;
    tw_state_t        state_nxt;
    logic [LOG2N-1:0] k_q;
    logic             inv_q;
    logic [DW-1:0]    ta_q;
    logic [ROM_AW-1:0] addr_a;
    logic [ROM_AW-1:0] addr_b;
    logic [DW-1:0]    fold_re;
    logic [DW-1:0]    fold_im;

    assign in_ready = (state == IDLE);
    assign addr_a   = {1'b0, k_q[9:0]};
    assign addr_b   = ROM_AW'(QUARTER) - addr_a;

    always_comb begin
        state_nxt = state;
        rom_ce    = 1'b0;
        rom_ad    = '0;
        unique case (state)
            IDLE: if (in_valid) state_nxt = RD_A;
            RD_A: begin
                rom_ce    = 1'b1;
                rom_ad    = addr_a;
                state_nxt = RD_B;
            end
            RD_B: begin
                rom_ce    = 1'b1;
                rom_ad    = addr_b;
                state_nxt = RD_C;
            end
            RD_C: begin
                rom_ad    = addr_b;
                state_nxt = OUT;
            end
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rom_dout during RD_C carries the B sample; tA was captured a cycle earlier
    twiddle_fold u_fold (
        .q   (k_q[11:10]),
        .inv (inv_q),
        .ta  (ta_q),
        .tb  (rom_dout),
        .re  (fold_re),
        .im  (fold_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_q       <= '0;
            inv_q     <= 1'b0;
            ta_q      <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                k_q   <= in_k;
                inv_q <= in_inv;
            end
            if (state == RD_B) ta_q <= rom_dout;
            if (state == RD_C) begin
                out_re    <= fold_re;
                out_im    <= fold_im;
                out_valid <= 1'b1;
            end
            if (state == OUT && out_ready) out_valid <= 1'b0;
        end
    end

endmodule
